// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared definitions for the MIPS32 forwarding / hazard controller:
//   - bypass mux select codes (must match the EX-stage 4-to-1 operand muxes)
//   - the register-zero index, which never takes part in forwarding
//   - the per-stage destination tag carried alongside EX, MEM and WB
//   - isWriter(): true when a stage tag really updates a GPR
// No ports; imported by the controller and its select sub-module.
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wr_en;
    logic       is_load;
  } stage_tag_t;

  // A stage only produces a forwardable value when it holds a real
  // instruction that writes a register other than $0.
  function automatic logic isWriter(input stage_tag_t tag);
    return tag.valid && tag.wr_en && (tag.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundle between the decode stage and the forwarding / hazard controller.
//   Decode -> controller : id_valid, id_flush, id_rs, id_rt, id_use_rs,
//                          id_use_rt, id_dst, id_wr_en, id_is_load,
//                          id_is_muldiv, id_reads_hilo
//   Controller -> core   : stall, ex_bubble, ex_fwd_a, ex_fwd_b, muldiv_busy
// modport master : the decode side (drives the id_* fields)
// modport slave  : the controller (drives stall / bubble / selects / busy)
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if;

  logic       id_valid;
  logic       id_flush;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_wr_en;
  logic       id_is_load;
  logic       id_is_muldiv;
  logic       id_reads_hilo;

  logic       stall;
  logic       ex_bubble;
  logic [1:0] ex_fwd_a;
  logic [1:0] ex_fwd_b;
  logic       muldiv_busy;

  modport master (
    output id_valid, id_flush, id_rs, id_rt, id_use_rs, id_use_rt,
           id_dst, id_wr_en, id_is_load, id_is_muldiv, id_reads_hilo,
    input  stall, ex_bubble, ex_fwd_a, ex_fwd_b, muldiv_busy
  );

  modport slave (
    input  id_valid, id_flush, id_rs, id_rt, id_use_rs, id_use_rt,
           id_dst, id_wr_en, id_is_load, id_is_muldiv, id_reads_hilo,
    output stall, ex_bubble, ex_fwd_a, ex_fwd_b, muldiv_busy
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel_calc.sv
// ---------------------------------------------------------------------------
// fwd_sel_calc
// Purely combinational bypass select for one source operand of the
// instruction in ID, looking at the destination tags of EX, MEM and WB.
// Ports:
//   i_src     : source register number
//   i_use     : the ID instruction really reads this source
//   i_ex/i_mem/i_wb : stage tags
//   o_sel     : FWD_RF / FWD_EXMEM / FWD_MEMWB / FWD_WB
//   o_loadHit : the matching producer is a load still in EX (load-use)
// ---------------------------------------------------------------------------
module fwd_sel_calc
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_use,
  input  stage_tag_t i_ex,
  input  stage_tag_t i_mem,
  input  stage_tag_t i_wb,
  output logic [1:0] o_sel,
  output logic       o_loadHit
);

  // Only the EX stage's load flag matters; a load in MEM or WB is forwarded
  // like any other result, so those two flags are deliberately dropped.
  logic w_unused;
  assign w_unused = i_mem.is_load ^ i_wb.is_load;

  // Youngest producer wins: EX is checked before MEM, MEM before WB.
  always_comb begin
    o_sel     = FWD_RF;
    o_loadHit = 1'b0;
    if (i_use && (i_src != REG_ZERO)) begin
      if (isWriter(i_ex) && (i_ex.dst == i_src)) begin
        o_sel     = FWD_EXMEM;
        o_loadHit = i_ex.is_load;
      end else if (isWriter(i_mem) && (i_mem.dst == i_src)) begin
        o_sel = FWD_MEMWB;
      end else if (isWriter(i_wb) && (i_wb.dst == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for the 5-stage MIPS32 core. Tracks the
// destination tags of EX, MEM and WB, registers the EX operand bypass
// selects, detects load-use and HI/LO busy hazards, and inserts stalls and
// bubbles. Decode redirects (id_flush) override hazards.
// Parameters:
//   MULDIV_CYCLES : cycles HI/LO stays busy after a mult/div enters EX
//   CNT_W         : busy counter width (2**CNT_W > MULDIV_CYCLES)
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : fwd_hazard_ctrl_if.slave (decode inputs, stall/bubble/select/
//            busy outputs)
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_ctrl_if.slave io_bus
);

  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_CYCLES);

  stage_tag_t       r_exTag;
  stage_tag_t       r_memTag;
  stage_tag_t       r_wbTag;
  logic [1:0]       r_fwdA;
  logic [1:0]       r_fwdB;
  logic [CNT_W-1:0] r_busyCnt;

  stage_tag_t       w_idTag;
  logic             w_useRs;
  logic             w_useRt;
  logic [1:0]       w_selA;
  logic [1:0]       w_selB;
  logic             w_loadHitA;
  logic             w_loadHitB;
  logic             w_loadUse;
  logic             w_busy;
  logic             w_busyHazard;
  logic             w_bubble;
  logic             w_muldivIssue;

  // A source only counts when ID holds a real instruction that reads it.
  assign w_useRs = io_bus.id_valid & io_bus.id_use_rs;
  assign w_useRt = io_bus.id_valid & io_bus.id_use_rt;

  // Tag the ID instruction would carry into EX if it advances.
  always_comb begin
    w_idTag         = '0;
    w_idTag.valid   = io_bus.id_valid;
    w_idTag.dst     = io_bus.id_dst;
    w_idTag.wr_en   = io_bus.id_wr_en;
    w_idTag.is_load = io_bus.id_is_load;
  end

  fwd_sel_calc u_selA (
    .i_src     (io_bus.id_rs),
    .i_use     (w_useRs),
    .i_ex      (r_exTag),
    .i_mem     (r_memTag),
    .i_wb      (r_wbTag),
    .o_sel     (w_selA),
    .o_loadHit (w_loadHitA)
  );

  fwd_sel_calc u_selB (
    .i_src     (io_bus.id_rt),
    .i_use     (w_useRt),
    .i_ex      (r_exTag),
    .i_mem     (r_memTag),
    .i_wb      (r_wbTag),
    .o_sel     (w_selB),
    .o_loadHit (w_loadHitB)
  );

  // Both hazard kinds merge into a single stall/bubble; a flush always
  // bubbles EX but never stalls, since the redirect discards the ID slot.
  assign w_loadUse     = w_loadHitA | w_loadHitB;
  assign w_busy        = (r_busyCnt != '0);
  assign w_busyHazard  = io_bus.id_valid & (io_bus.id_reads_hilo | io_bus.id_is_muldiv) & w_busy;
  assign w_bubble      = w_loadUse | w_busyHazard | io_bus.id_flush;
  assign w_muldivIssue = io_bus.id_valid & io_bus.id_is_muldiv & ~w_bubble;

  assign io_bus.stall       = (w_loadUse | w_busyHazard) & ~io_bus.id_flush;
  assign io_bus.ex_bubble   = w_bubble;
  assign io_bus.ex_fwd_a    = r_fwdA;
  assign io_bus.ex_fwd_b    = r_fwdB;
  assign io_bus.muldiv_busy = w_busy;

  // Stage tags shift every cycle. A bubble enters EX as an all-zero tag,
  // and the registered selects for a bubble point at the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exTag  <= '0;
      r_memTag <= '0;
      r_wbTag  <= '0;
      r_fwdA   <= FWD_RF;
      r_fwdB   <= FWD_RF;
    end else begin
      r_memTag <= r_exTag;
      r_wbTag  <= r_memTag;
      if (w_bubble) begin
        r_exTag <= '0;
        r_fwdA  <= FWD_RF;
        r_fwdB  <= FWD_RF;
      end else begin
        r_exTag <= w_idTag;
        r_fwdA  <= w_selA;
        r_fwdB  <= w_selB;
      end
    end
  end

  // HI/LO busy countdown. A mult/div that actually reaches EX reloads the
  // count, which wins over the decrement on the cycle the count hits zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busyCnt <= '0;
    end else if (w_muldivIssue) begin
      r_busyCnt <= BUSY_LOAD;
    end else if (w_busy) begin
      r_busyCnt <= r_busyCnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed bench for fwd_hazard_ctrl. A history of issued instructions,
// indexed by the cycle each left ID, acts as the reference: a producer
// that left ID d cycles ago sits at pipeline distance d, which is also its
// bypass code. Literal expectations in the directed sequence pin the model.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int MULDIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checkCount = 0;
  int failCount  = 0;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl #(
    .MULDIV_CYCLES (MULDIV),
    .CNT_W         (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Free-running core clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: queue of instructions that left ID, with issue cycle.
  // ---------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       md;
  } issued_t;

  issued_t    hist[$];
  int         cycNow   = 0;
  logic [1:0] expFwdA  = 2'b00;
  logic [1:0] expFwdB  = 2'b00;
  logic [1:0] pendFwdA = 2'b00;
  logic [1:0] pendFwdB = 2'b00;
  logic       pendPush = 1'b0;
  issued_t    pendEntry;

  function automatic int findAt(input int d);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].cyc == cycNow - d) return i;
    return -1;
  endfunction

  function automatic logic [1:0] modelSel(input logic valid, input logic used, input logic [4:0] src);
    int idx;
    if (!valid || !used || src == 5'd0) return 2'd0;
    for (int d = 1; d <= 3; d++) begin
      idx = findAt(d);
      if (idx >= 0 && hist[idx].wr && hist[idx].dst == src) return 2'(d);
    end
    return 2'd0;
  endfunction

  function automatic logic modelLoadUse(input logic valid, input logic useRs, input logic [4:0] rs,
                                        input logic useRt, input logic [4:0] rt);
    int idx;
    idx = findAt(1);
    if (idx < 0 || !valid) return 1'b0;
    if (!(hist[idx].ld && hist[idx].wr && hist[idx].dst != 5'd0)) return 1'b0;
    return (useRs && rs == hist[idx].dst) || (useRt && rt == hist[idx].dst);
  endfunction

  function automatic logic modelBusy();
    foreach (hist[i])
      if (hist[i].md && (cycNow - hist[i].cyc) >= 1 && (cycNow - hist[i].cyc) <= MULDIV) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every cycle on the falling edge, then queue what the next
  // rising edge should do to the model.
  logic mLoadUse, mBusy, mBusyHaz, mStall, mBubble;
  always @(negedge clk) begin
    mBusy    = modelBusy();
    mLoadUse = modelLoadUse(bus.id_valid, bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt);
    mBusyHaz = bus.id_valid && (bus.id_reads_hilo || bus.id_is_muldiv) && mBusy;
    mStall   = (mLoadUse || mBusyHaz) && !bus.id_flush;
    mBubble  = mLoadUse || mBusyHaz || bus.id_flush;
    checkOutput("model_stall", bus.stall, mStall);
    checkOutput("model_bubble", bus.ex_bubble, mBubble);
    checkOutput("model_fwd_a", bus.ex_fwd_a, expFwdA);
    checkOutput("model_fwd_b", bus.ex_fwd_b, expFwdB);
    checkOutput("model_busy", bus.muldiv_busy, mBusy);
    pendPush      = rst_n && !mBubble && bus.id_valid;
    pendEntry.cyc = cycNow;
    pendEntry.dst = bus.id_dst;
    pendEntry.wr  = bus.id_wr_en;
    pendEntry.ld  = bus.id_is_load;
    pendEntry.md  = bus.id_is_muldiv;
    pendFwdA      = mBubble ? 2'd0 : modelSel(bus.id_valid, bus.id_use_rs, bus.id_rs);
    pendFwdB      = mBubble ? 2'd0 : modelSel(bus.id_valid, bus.id_use_rt, bus.id_rt);
  end

  // Advance the model on the rising edge; reset empties the pipeline.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      expFwdA <= 2'd0;
      expFwdB <= 2'd0;
    end else begin
      if (pendPush) hist.push_back(pendEntry);
      while (hist.size() > 0 && cycNow - hist[0].cyc > 64) hist.pop_front();
      expFwdA <= pendFwdA;
      expFwdB <= pendFwdB;
      cycNow  <= cycNow + 1;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change just after a rising edge, and each
  // call returns on the following falling edge for sampling.
  // ---------------------------------------------------------------------
  task automatic applyStimulus(input logic v, input logic fl, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                               input logic wr, input logic ld, input logic md, input logic hilo);
    @(posedge clk);
    #1;
    bus.id_valid      = v;
    bus.id_flush      = fl;
    bus.id_rs         = rs;
    bus.id_use_rs     = urs;
    bus.id_rt         = rt;
    bus.id_use_rt     = urt;
    bus.id_dst        = dst;
    bus.id_wr_en      = wr;
    bus.id_is_load    = ld;
    bus.id_is_muldiv  = md;
    bus.id_reads_hilo = hilo;
    @(negedge clk);
  endtask

  task automatic issueNop();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic issueAlu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt, input logic fl = 0);
    applyStimulus(1, fl, rs, 1, rt, 1, dst, 1, 0, 0, 0);
  endtask

  task automatic issueLoad(input logic [4:0] dst, input logic [4:0] base);
    applyStimulus(1, 0, base, 1, 5'd0, 0, dst, 1, 1, 0, 0);
  endtask

  task automatic issueMul(input logic fl = 0);
    applyStimulus(1, fl, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0);
  endtask

  task automatic issueMfhi(input logic [4:0] dst);
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, dst, 1, 0, 0, 1);
  endtask

  task automatic holdReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_stall", bus.stall, 0);
    checkOutput("rst_bubble", bus.ex_bubble, 0);
    checkOutput("rst_fwd_a", bus.ex_fwd_a, 0);
    checkOutput("rst_fwd_b", bus.ex_fwd_b, 0);
    checkOutput("rst_busy", bus.muldiv_busy, 0);
    bus.id_valid = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_wr_en = 0; bus.id_is_load = 0; bus.id_is_muldiv = 0; bus.id_reads_hilo = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Bound the whole run in case the design never lets the bench proceed.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence with hand-computed expectations.
  int stalls;
  int busyCycles;
  initial begin
    bus.id_valid = 0; bus.id_flush = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_dst = 0; bus.id_wr_en = 0;
    bus.id_is_load = 0; bus.id_is_muldiv = 0; bus.id_reads_hilo = 0;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_stall", bus.stall, 0);
    checkOutput("reset_bubble", bus.ex_bubble, 0);
    checkOutput("reset_fwd_a", bus.ex_fwd_a, 0);
    checkOutput("reset_fwd_b", bus.ex_fwd_b, 0);
    checkOutput("reset_busy", bus.muldiv_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] forwarding distance");
    issueAlu(5'd3, 5'd1, 5'd2);
    issueAlu(5'd10, 5'd3, 5'd0);
    checkOutput("adj_stall", bus.stall, 0);
    issueNop();
    checkOutput("adj_fwd_a", bus.ex_fwd_a, 2'b01);

    issueAlu(5'd4, 5'd1, 5'd2);
    issueAlu(5'd20, 5'd1, 5'd2);
    issueAlu(5'd11, 5'd4, 5'd0);
    issueNop();
    checkOutput("gap1_fwd_a", bus.ex_fwd_a, 2'b10);

    issueAlu(5'd5, 5'd1, 5'd2);
    issueAlu(5'd20, 5'd1, 5'd2);
    issueAlu(5'd21, 5'd1, 5'd2);
    issueAlu(5'd11, 5'd5, 5'd0);
    issueNop();
    checkOutput("gap2_fwd_a", bus.ex_fwd_a, 2'b11);

    issueAlu(5'd6, 5'd1, 5'd2);
    issueAlu(5'd20, 5'd1, 5'd2);
    issueAlu(5'd21, 5'd1, 5'd2);
    issueAlu(5'd22, 5'd1, 5'd2);
    issueAlu(5'd11, 5'd6, 5'd0);
    issueNop();
    checkOutput("gap3_fwd_a", bus.ex_fwd_a, 2'b00);

    $display("[TB] load-use");
    issueLoad(5'd8, 5'd1);
    issueAlu(5'd12, 5'd1, 5'd8);
    checkOutput("lu_stall", bus.stall, 1);
    checkOutput("lu_bubble", bus.ex_bubble, 1);
    issueAlu(5'd12, 5'd1, 5'd8);
    checkOutput("lu_release_stall", bus.stall, 0);
    checkOutput("lu_release_bubble", bus.ex_bubble, 0);
    checkOutput("lu_bubble_fwd_b", bus.ex_fwd_b, 2'b00);
    issueNop();
    checkOutput("lu_fwd_b", bus.ex_fwd_b, 2'b10);

    issueLoad(5'd0, 5'd1);
    issueAlu(5'd12, 5'd1, 5'd0);
    checkOutput("lu_r0_stall", bus.stall, 0);
    issueNop();
    checkOutput("lu_r0_fwd_b", bus.ex_fwd_b, 2'b00);

    $display("[TB] priority");
    issueAlu(5'd7, 5'd1, 5'd2);
    issueAlu(5'd7, 5'd1, 5'd2);
    issueAlu(5'd13, 5'd7, 5'd2);
    issueNop();
    checkOutput("prio_fwd_a", bus.ex_fwd_a, 2'b01);

    $display("[TB] mult then mfhi");
    issueMul();
    stalls = 0; busyCycles = 0;
    for (int i = 0; i < 10; i++) begin
      issueMfhi(5'd14);
      if (bus.muldiv_busy) busyCycles++;
      if (!bus.stall) break;
      stalls++;
    end
    checkOutput("mfhi_stalls", 8'(stalls), 8'd4);
    checkOutput("mfhi_busy_cycles", 8'(busyCycles), 8'd4);

    issueMul();
    issueAlu(5'd21, 5'd1, 5'd2);
    checkOutput("mul_addu_stall", bus.stall, 0);
    checkOutput("mul_addu_busy", bus.muldiv_busy, 1);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      issueMfhi(5'd14);
      if (!bus.stall) break;
      stalls++;
    end
    checkOutput("mfhi_after_addu_stalls", 8'(stalls), 8'd3);

    issueMul();
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      issueMul();
      if (!bus.stall) break;
      stalls++;
    end
    checkOutput("mul_mul_stalls", 8'(stalls), 8'd4);
    busyCycles = 0;
    for (int i = 0; i < 10; i++) begin
      issueNop();
      if (!bus.muldiv_busy) break;
      busyCycles++;
    end
    checkOutput("reload_busy_cycles", 8'(busyCycles), 8'd4);

    $display("[TB] flush");
    issueLoad(5'd9, 5'd1);
    issueAlu(5'd12, 5'd9, 5'd2, 1'b1);
    checkOutput("flush_bubble", bus.ex_bubble, 1);
    checkOutput("flush_stall", bus.stall, 0);
    issueNop();
    checkOutput("flush_fwd_a", bus.ex_fwd_a, 2'b00);
    issueMul(1'b1);
    issueNop();
    checkOutput("flush_mul_busy", bus.muldiv_busy, 0);

    $display("[TB] reset mid-operation");
    issueMul();
    issueNop();
    issueNop();
    issueNop();
    checkOutput("pre_rst_busy", bus.muldiv_busy, 1);
    holdReset();
    issueLoad(5'd15, 5'd1);
    issueAlu(5'd16, 5'd15, 5'd2);
    checkOutput("pre_rst_stall", bus.stall, 1);
    holdReset();
    issueAlu(5'd16, 5'd15, 5'd2);
    checkOutput("post_rst_stall", bus.stall, 0);
    issueNop();
    checkOutput("post_rst_fwd_a", bus.ex_fwd_a, 2'b00);
    issueNop();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
